// File: rtl/wb_pkg.sv
// Shared encodings for the write-back controller and MUX_DW: write-back class,
// dw_sel source codes and controller FSM states.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_NONE = 2'b00,
    WB_ALU  = 2'b01,
    WB_LOAD = 2'b10,
    WB_LINK = 2'b11
  } wb_type_e;

  typedef enum logic [1:0] {
    DW_ALU  = 2'b00,
    DW_MEM  = 2'b01,
    DW_PC   = 2'b10,
    DW_IDLE = 2'b11
  } dw_sel_e;

  // 2'b11 is unused and recovers to ST_IDLE
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_WB       = 2'b10
  } wb_state_e;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Load-wait counter: counts cycles spent waiting for mem_ack and flags the
// last allowed cycle. Only instantiated when WB_TIMEOUT_EN is defined.
module wb_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  // High in the TIMEOUT_CYC-th waiting cycle, so the FSM leaves on that edge
  assign expired_c = en && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/wb_ctrl.sv
// Write-back controller for the register-file write port: drives MUX_DW select,
// rf write strobe/address, load handshake and PC stall. Optional WB_TIMEOUT_EN.
module wb_ctrl
  import wb_pkg::*;
#(
  parameter int unsigned AW          = 5,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [1:0]       wb_type,
  input  logic [AW-1:0]    rd_addr,
  output logic             mem_req,
  input  logic             mem_ack,
  output logic [1:0]       dw_sel,
  output logic             rf_we,
  output logic [AW-1:0]    rf_waddr,
  output logic             pc_stall,
  output logic [CNT_W-1:0] wb_count
`ifdef WB_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);

  wb_state_e     state, state_nxt;
  logic          mem_req_nxt;
  dw_sel_e       dw_sel_nxt;
  logic          rf_we_nxt;
  logic [AW-1:0] rf_waddr_nxt;

  assign instr_ready = (state == ST_IDLE);
  assign pc_stall    = (state != ST_IDLE);

`ifdef WB_TIMEOUT_EN
  logic tmo_clr;
  logic tmo_expired;
  logic timeout_err_nxt;

  wb_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (tmo_clr),
    .en        (state == ST_MEM_WAIT),
    .expired_c (tmo_expired)
  );
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

  // Next-state and next-output decode
  always_comb begin
    state_nxt    = state;
    mem_req_nxt  = mem_req;
    dw_sel_nxt   = dw_sel_e'(dw_sel);
    rf_we_nxt    = 1'b0;
    rf_waddr_nxt = rf_waddr;
`ifdef WB_TIMEOUT_EN
    tmo_clr         = 1'b0;
    timeout_err_nxt = timeout_err;
`endif
    case (state)
      ST_IDLE: begin
        if (instr_valid) begin
          rf_waddr_nxt = rd_addr;
          case (wb_type_e'(wb_type))
            WB_ALU: begin
              state_nxt  = ST_WB;
              dw_sel_nxt = DW_ALU;
              rf_we_nxt  = |rd_addr;
            end
            WB_LINK: begin
              state_nxt  = ST_WB;
              dw_sel_nxt = DW_PC;
              rf_we_nxt  = |rd_addr;
            end
            WB_LOAD: begin
              state_nxt   = ST_MEM_WAIT;
              mem_req_nxt = 1'b1;
`ifdef WB_TIMEOUT_EN
              tmo_clr     = 1'b1;
`endif
            end
            default: ;
          endcase
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          state_nxt   = ST_WB;
          mem_req_nxt = 1'b0;
          dw_sel_nxt  = DW_MEM;
          rf_we_nxt   = |rf_waddr;
        end
`ifdef WB_TIMEOUT_EN
        else if (tmo_expired) begin
          state_nxt       = ST_IDLE;
          mem_req_nxt     = 1'b0;
          timeout_err_nxt = 1'b1;
        end
`endif
      end
      ST_WB: begin
        state_nxt  = ST_IDLE;
        dw_sel_nxt = DW_IDLE;
      end
      default: begin
        state_nxt   = ST_IDLE;
        mem_req_nxt = 1'b0;
        dw_sel_nxt  = DW_IDLE;
      end
    endcase
  end

  // State and registered outputs; wb_count retires on the rf_we cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      mem_req  <= 1'b0;
      dw_sel   <= DW_IDLE;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      wb_count <= '0;
`ifdef WB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      mem_req  <= mem_req_nxt;
      dw_sel   <= dw_sel_nxt;
      rf_we    <= rf_we_nxt;
      rf_waddr <= rf_waddr_nxt;
      if (rf_we) begin
        wb_count <= wb_count + CNT_W'(1);
      end
`ifdef WB_TIMEOUT_EN
      timeout_err <= timeout_err_nxt;
`endif
    end
  end

endmodule
